// File: rtl/segmax_pkg.sv
// Shared types and helpers for the streaming segmented max finder.
package segmax_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {SEG1 = 2'd0, SEG2 = 2'd1, SEG4 = 2'd2} seg_mode_e;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;

   // Reserved mode 3 folds to one segment; four segments need at least 8 lanes.
   function automatic int seg_count(input logic [1:0] mode, input int lanes);
      case (seg_mode_e'(mode))
         SEG2:    return 2;
         SEG4:    return (lanes >= 8) ? 4 : 2;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/segmax_tree.sv
// Combinational signed max tree over one beat, tapped per segment.
module segmax_tree
   import segmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LANES  = 8
) (
   input  logic [LANES*DATA_W-1:0] data_i,
   input  logic [1:0]              seg_lg_i,
   output logic [LANES*DATA_W-1:0] seg_max_o
);

   // Heap layout: leaves at LANES..2*LANES-1, node n covers 2n and 2n+1,
   // so the S segment maxima of an S-way split sit at nodes S..2S-1.
   logic [DATA_W-1:0] node [1:2*LANES-1];

   for (genvar i = 0; i < LANES; i++) begin : g_leaf
      assign node[LANES+i] = data_i[i*DATA_W +: DATA_W];
   end

   for (genvar n = 1; n < LANES; n++) begin : g_node
      assign node[n] = ($signed(node[2*n]) > $signed(node[2*n+1])) ? node[2*n] : node[2*n+1];
   end

   for (genvar k = 0; k < LANES; k++) begin : g_tap
      localparam int  N2   = (k < 2) ? 2 + k : 1;
      localparam bit  USE4 = (k < 4) && (4 + k < 2*LANES);
      localparam int  N4   = USE4 ? 4 + k : 1;
      assign seg_max_o[k*DATA_W +: DATA_W] =
         (seg_lg_i == 2'd2) ? (USE4   ? node[N4] : '0) :
         (seg_lg_i == 2'd1) ? ((k < 2) ? node[N2] : '0) :
                              ((k == 0) ? node[1] : '0);
   end

endmodule

// File: rtl/segmax_stream.sv
// Streaming per-segment running max over the beats of a row, one result per row.
module segmax_stream
   import segmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LANES  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              seg_mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_max,
   output logic [CNT_W-1:0]        out_beats
);

   function automatic logic [1:0] lg_of(input logic [1:0] mode);
      int n;
      n = seg_count(mode, LANES);
      return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
   endfunction

   state_e                         state_q, state_d;
   logic [1:0]                     mode_lg_q, cur_lg;
   logic                           s1_valid_q, s1_last_q, s1_first_q;
   logic [LANES-1:0][DATA_W-1:0]   s1_data_q, tree_max;
   logic [LANES-1:0][DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           out_valid_q, last_inflight_q;
   logic [LANES-1:0][DATA_W-1:0]   out_max_q;
   logic [CNT_W-1:0]               out_beats_q;
   logic                           accept, first;

   assign in_ready  = !out_valid_q && !last_inflight_q;
   assign accept    = in_valid && in_ready;
   assign first     = (state_q == IDLE);
   assign cur_lg    = first ? lg_of(seg_mode) : mode_lg_q;
   assign out_valid = out_valid_q;
   assign out_max   = out_max_q;
   assign out_beats = out_beats_q;

   segmax_tree #(.DATA_W(DATA_W), .LANES(LANES)) u_tree (
      .data_i    (in_data),
      .seg_lg_i  (cur_lg),
      .seg_max_o (tree_max)
   );

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         if (s1_first_q || ($signed(s1_data_q[k]) > $signed(acc_q[k]))) acc_d[k] = s1_data_q[k];
         else                                                           acc_d[k] = acc_q[k];
      end
      if (s1_first_q)  cnt_d = CNT_W'(1);
      else if (&cnt_q) cnt_d = cnt_q;
      else             cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCUM;
         ACCUM:   if (s1_valid_q && s1_last_q) state_d = DONE;
         DONE:    if (out_valid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         mode_lg_q       <= 2'd0;
         s1_valid_q      <= 1'b0;
         s1_last_q       <= 1'b0;
         s1_first_q      <= 1'b0;
         s1_data_q       <= '0;
         acc_q           <= '0;
         cnt_q           <= '0;
         out_valid_q     <= 1'b0;
         out_max_q       <= '0;
         out_beats_q     <= '0;
         last_inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= accept;
         if (accept) begin
            s1_data_q  <= tree_max;
            s1_last_q  <= in_last;
            s1_first_q <= first;
            if (first) mode_lg_q <= cur_lg;
            if (in_last) last_inflight_q <= 1'b1;
         end
         if (s1_valid_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
         end
         // Result loads straight from the accumulate inputs so it lands at T+2.
         if (s1_valid_q && s1_last_q) begin
            out_valid_q     <= 1'b1;
            out_max_q       <= acc_d;
            out_beats_q     <= cnt_d;
            last_inflight_q <= 1'b0;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_segmax_stream.sv
// Randomized self-checking bench for segmax_stream against a row-level max model.
module tb_segmax_stream;

   localparam int DW = 32;
   localparam int LN = 8;
   localparam int CW = 4;
   localparam int W  = DW*LN;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    seg_mode = 2'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_max;
   logic [CW-1:0] out_beats;

   int nvec = 0;
   int nbad = 0;
   int cyc  = 0;

   logic [W-1:0] rb[$];
   logic [1:0]   rm[$];

   segmax_stream #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .seg_mode(seg_mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_beats(out_beats)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   // Row result: max over every lane of every beat belonging to each segment.
   function automatic logic [W-1:0] model_max();
      int s, len, v;
      int best[8];
      logic [W-1:0] r;
      r = '0;
      case (rm[0])
         2'd1:    s = 2;
         2'd2:    s = 4;
         default: s = 1;
      endcase
      len = LN / s;
      for (int k = 0; k < 8; k++) best[k] = int'(32'h8000_0000);
      for (int b = 0; b < rb.size(); b++)
         for (int l = 0; l < LN; l++) begin
            v = int'(rb[b][l*DW +: DW]);
            if (v > best[l/len]) best[l/len] = v;
         end
      for (int k = 0; k < s; k++) r[k*DW +: DW] = best[k];
      return r;
   endfunction

   task automatic drive_beats(input bit with_last, input bit bubbles, output int acc_cyc);
      int t;
      acc_cyc = 0;
      for (int b = 0; b < rb.size(); b++) begin
         if (bubbles && b > 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = rb[b];
         seg_mode = rm[b];
         in_last  = with_last && (b == rb.size() - 1);
         @(negedge clk);
         t = 0;
         while (!in_ready && t < 50) begin @(negedge clk); t++; end
         if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
         acc_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_row(input int bp, input bit bubbles);
      int t, acc_cyc, nb;
      logic [W-1:0]  em, held;
      logic [CW-1:0] eb;
      nb = rb.size();
      em = model_max();
      eb = (nb > 15) ? CW'(15) : CW'(nb);
      drive_beats(1'b1, bubbles, acc_cyc);
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      check("out_valid", W'(out_valid), W'(1));
      check("latency", W'(cyc - acc_cyc), W'(2));
      check("out_max", out_max, em);
      check("out_beats", W'(out_beats), W'(eb));
      held = out_max;
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         seg_mode = 2'($urandom_range(0, 3));
         @(negedge clk);
         check("bp_valid", W'(out_valid), W'(1));
         check("bp_max", out_max, held);
         check("bp_beats", W'(out_beats), W'(eb));
         check("bp_in_ready", W'(in_ready), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ov_clear", W'(out_valid), W'(0));
      check("in_ready_after", W'(in_ready), W'(1));
   endtask

   function automatic int rnd_lane();
      case ($urandom_range(0, 3))
         0:       return int'($urandom);
         1:       return int'(32'h8000_0000) + int'($urandom_range(0, 3));
         2:       return int'(32'h7fff_ffff) - int'($urandom_range(0, 3));
         default: return int'($urandom_range(0, 20)) - 10;
      endcase
   endfunction

   initial begin
      int c;
      bit seen;
      logic [W-1:0] v;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_max", out_max, '0);
      check("rst_out_beats", W'(out_beats), W'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_in_ready", W'(in_ready), W'(1));

      // Single-beat row, one segment
      rb = {}; rm = {};
      rb.push_back(pk(5, -3, 9, 1, 0, -8, 2, 7)); rm.push_back(2'd0);
      run_row(0, 1'b0);

      // Two segments across two beats
      rb = {}; rm = {};
      rb.push_back(pk(-1, -2, -3, -4, -5, -6, -7, -8)); rm.push_back(2'd1);
      rb.push_back(pk(-9, -2, -3, -4, 4, 3, 2, 1));     rm.push_back(2'd1);
      run_row(0, 1'b0);

      // Four segments at the negative extreme
      rb = {}; rm = {};
      v = {8{32'h8000_0000}};
      v[5*DW +: DW] = 32'h8000_0001;
      rb.push_back(v); rm.push_back(2'd2);
      run_row(0, 1'b0);

      // Backpressure, then the next row
      rb = {}; rm = {};
      rb.push_back(pk(3, 1, 4, 1, 5, 9, 2, 6)); rm.push_back(2'd1);
      rb.push_back(pk(-5, 8, -9, 7, 0, 0, 1, 1)); rm.push_back(2'd0);
      run_row(5, 1'b0);
      rb = {}; rm = {};
      rb.push_back(pk(10, 20, 30, 40, 50, 60, 70, 80)); rm.push_back(2'd2);
      run_row(0, 1'b0);

      // Reset mid-row discards everything
      rb = {}; rm = {};
      for (int b = 0; b < 3; b++) begin rb.push_back(pk(99, 98, 97, 96, 95, 94, 93, 92)); rm.push_back(2'd0); end
      drive_beats(1'b0, 1'b0, c);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_in_ready", W'(in_ready), W'(1));
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      check("rst_mid_no_out", W'(seen), W'(0));
      @(posedge clk); #1;
      rb = {}; rm = {};
      rb.push_back(pk(1, 1, 1, 1, 1, 1, 1, 2)); rm.push_back(2'd0);
      run_row(0, 1'b0);

      // Saturating count with seg_mode toggling mid-row
      rb = {}; rm = {};
      for (int b = 0; b < 20; b++) begin
         rb.push_back(pk(b, -b, 2*b, 0, b - 7, 3, -1, b % 5));
         rm.push_back((b == 0) ? 2'd1 : 2'(b % 4));
      end
      run_row(1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         int nb;
         rb = {}; rm = {};
         nb = $urandom_range(1, 20);
         for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LN; l++) v[l*DW +: DW] = rnd_lane();
            rb.push_back(v);
            rm.push_back(2'($urandom_range(0, 3)));
         end
         run_row($urandom_range(0, 3), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/segmax_stream.md
Name: segmax_stream

Overview:
- Streaming, parametrised successor to the fixed 8-input segmented max finders.
- Accepts one LANES-wide beat of signed scores per cycle under valid/ready handshake.
- Reduces each beat per segment through a registered comparator tree, then keeps a running max per segment across all beats of a row until in_last.
- Emits one result beat per row; it feeds the softmax normalisation stage.

Parameters:
- DATA_W, 32, width of one signed lane.
- LANES, 8, lanes per beat; power of two, >= 2.
- CNT_W, 16, width of the per-row beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- seg_mode  input  2  segmentation select, sampled on the first beat of a row: 0 = 1 segment of LANES; 1 = 2 of LANES/2; 2 = 4 of LANES/4; 3 = reserved, treated as 0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed.
- in_last  input  1  final beat of the row.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- out_max  output  LANES*DATA_W  segment k max in lane k; lanes >= segment count are 0.
- out_beats  output  CNT_W  number of beats in the row, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - Applies to every register.
  - out_valid=0, out_max=0, out_beats=0, state IDLE.
  - Stage-1 and in-flight flags cleared; in_ready=1 the cycle after rst deasserts.
  - Reset mid-row or mid-result discards all partial state, with no output.
- Handshake:
  - Transfer occurs when valid && ready in the same cycle.
  - in_ready = !out_valid && !last_inflight, driven from registers only, so it has no combinational path from out_ready.
- Stage 1 (registered tree):
  - An accepted beat is reduced per segment with a signed ">" compare, giving the segment max.
  - Results go to s1_data together with s1_valid, s1_last and the latched mode.
- Stage 2 (accumulator), on s1_valid:
  - First beat of row: acc[k] = s1 max[k].
  - Later beats: acc[k] = max(acc[k], s1 max[k]), signed.
  - beat_cnt increments and saturates at 2^CNT_W-1.
- FSM:
  - IDLE -> ACCUM on the first accepted beat; seg_mode is latched here.
  - If that first beat has in_last=1, the FSM goes directly through ACCUM to DONE.
  - ACCUM -> DONE when s1_valid && s1_last.
  - On entering DONE, out_max and out_beats are loaded from the final accumulate values and out_valid=1.
  - DONE -> IDLE on out_valid && out_ready; out_valid clears the same cycle.
- last_inflight is set when an in_last beat is accepted and cleared when out_valid is set.
  - Beats of the next row are therefore never accepted while the current row is draining.
- Latency and throughput:
  - Last beat accepted at cycle T gives out_valid=1 at T+2.
  - Within a row: 1 beat/cycle.
  - Between rows: in_ready returns the cycle after the output handshake.
- Mode rules:
  - A seg_mode change mid-row is ignored until the next row.
  - Mode 2 with LANES < 8 behaves as the largest legal segment count.
- Arithmetic:
  - Compares are full-width two's complement; there is no overflow path.
  - On equal values either operand may be chosen, since they are bit-identical.
- out_max and out_beats are stable while out_valid && !out_ready.
- A single-beat row (in_last on the first beat) is legal: out_beats=1.

Decomposition:
- Package segmax_pkg holds:
  - the seg_mode_e enum (SEG1/SEG2/SEG4);
  - the state enum (IDLE/ACCUM/DONE);
  - the DATA_W default;
  - the function seg_count(mode, lanes).
- Sub-module segmax_tree: combinational LANES-input signed reduction with per-segment taps at each tree level, instanced once ahead of the stage-1 register.

Test Plan:
- Mode 0, one beat {5,-3,9,1,0,-8,2,7}, last=1 -> out_max lane0=9, other lanes 0, out_beats=1, out_valid exactly 2 cycles after acceptance.
- Mode 1, beats {-1..-8} then {-9,-2,-3,-4, 4,3,2,1}, last on beat 2 -> lane0=-1, lane1=4, out_beats=2.
- Mode 2, all lanes 0x8000_0000 except lane5=0x8000_0001 -> lanes 0,1,3 = 0x8000_0000, lane2 = 0x8000_0001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 while next-row beats are presented; release -> in_ready=1 the following cycle, next row correct.
- Assert rst for 1 cycle after 3 beats of a row -> no out_valid; a fresh 1-beat row {1,1,1,1,1,1,1,2} gives lane0=2.
- CNT_W=4 with a 20-beat row -> out_beats=15 (saturated), max correct; seg_mode toggled mid-row has no effect.
